// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: ready/valid word in, LSB-first serial frame out
// with start bit, optional even/odd parity and one or two stop bits.
module uart_tx_frame #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_B = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int IDX_W = $clog2(MAX_B) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLK_DIV - 2);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV out of range 2..65535");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W out of range 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   baud_cnt_reg;
    logic [IDX_W-1:0]   bit_idx_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic               parity_reg;
    logic               tx_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               bit_end;

    assign bit_end = (baud_cnt_reg == CNT_LAST);
    assign s_ready = (state_reg == S_IDLE);
    assign tx      = tx_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Baud counter wraps at the end of every bit, which coincides with every state change.
            if (state_reg != S_IDLE) begin
                baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (s_valid) begin
                        shift_reg    <= s_data;
                        parity_reg   <= (PARITY == 2) ? ~^s_data : ^s_data;
                        state_reg    <= S_START;
                        tx_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        baud_cnt_reg <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_reg   <= S_DATA;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == DATA_LAST) begin
                            bit_idx_reg <= '0;
                            if (PARITY != 0) begin
                                state_reg <= S_PARITY;
                                tx_reg    <= parity_reg;
                            end else begin
                                state_reg <= S_STOP;
                                tx_reg    <= 1'b1;
                            end
                        end else begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_reg   <= S_STOP;
                        tx_reg      <= 1'b1;
                        bit_idx_reg <= '0;
                    end
                end
                S_STOP: begin
                    // Registered pulse lands in the final cycle of the last stop bit.
                    if (bit_idx_reg == STOP_LAST && baud_cnt_reg == CNT_PRE) begin
                        done_reg <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_idx_reg == STOP_LAST) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with a ready/valid input and a programmable frame format. Data width, parity mode, stop-bit count and bit period are set by parameters. The block takes one word per handshake and serialises it LSB-first onto `tx`, framed by one start bit, optional parity and one or two stop bits. It sits between a byte/word source (FIFO or register interface) and the board-level TX pin, and replaces the fixed 8-bit, even-parity, one-bit-per-clock transmitter.

## Interface
Parameters:
- `CLK_DIV`, default 16: clock cycles per UART bit; legal range 2..65535.
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  source has a word on `s_data`.
- `s_ready`  out  1  block can accept a word this cycle.
- `s_data`  in  `DATA_W`  word to transmit; sampled on handshake.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  a frame is in progress (not IDLE).
- `done`  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Reset values: state IDLE, `tx`=1, `busy`=0, `done`=0, baud and bit counters 0. `s_ready`=1 from the first cycle after reset.
- While `rst`=1, `s_valid` is ignored and no handshake occurs.
- `s_ready` = (state == IDLE). A handshake happens when `s_valid` and `s_ready` are both high at a rising edge.
- On handshake:
  - latch `s_data` into the shift register;
  - compute the parity bit from the latched word: even gives `^data`, odd gives `~^data`;
  - move to START.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current LSB of the shift register; shift right once per bit period; `DATA_W` bit periods.
  - PARITY: `tx` = parity bit; this state is skipped when `PARITY`=0.
  - STOP: `tx`=1 for `STOP_BITS` bit periods, then return to IDLE.
- Baud counter:
  - counts 0..`CLK_DIV`-1 and resets to 0 on every state change;
  - a bit period ends when the count reaches `CLK_DIV`-1;
  - width is clog2(`CLK_DIV`).
- Bit index counter: counts data bits and stop bits; width is clog2(max(`DATA_W`, `STOP_BITS`))+1.
- `s_data` changes while busy have no effect on the frame in flight.
- Out-of-range parameters are a compile-time error (generate-time check). The block does not clamp them.
- Reset mid-frame: on the next edge `tx`=1, state IDLE, `done` not pulsed. The partial frame is abandoned, not completed.

## Timing
- `tx` is registered, with no combinational path from any input to `tx`.
- Handshake at edge k: `tx` falls at edge k+1, and `busy` rises at edge k+1.
- Every bit, including each stop bit, holds `tx` stable for exactly `CLK_DIV` cycles.
- Frame length F = 1 + `DATA_W` + (`PARITY`≠0) + `STOP_BITS` bits, i.e. F×`CLK_DIV` cycles from the falling edge of `tx` to the end of the last stop bit.
- `done` is high for exactly one cycle: the last cycle of the final stop bit.
- The next edge returns the FSM to IDLE, and `s_ready` rises there.
- Back-to-back traffic:
  - with `s_valid` held high, the next handshake occurs in that IDLE cycle;
  - consecutive frames are therefore separated by exactly one extra idle-high cycle;
  - frame-to-frame period is F×`CLK_DIV`+1 cycles.
- Throughput: one word per F×`CLK_DIV`+1 cycles maximum.

## Test plan
- `CLK_DIV`=4, `DATA_W`=8, `PARITY`=1, `STOP_BITS`=1; send 0xA5.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0,1.
  - 44 cycles in total; `done` pulses once in cycle 44.
  - `s_ready` low from cycle 1 to cycle 44.
- Same configuration with `PARITY`=2; send 0xA5.
  - parity bit is 1; every other bit is unchanged.
- `PARITY`=0, `DATA_W`=7, `STOP_BITS`=2; send 0x55.
  - sequence 0,1,0,1,0,1,0,1,1,1: 10 bits, 40 cycles.
  - no parity slot; the two stop bits hold 8 cycles high.
- `s_valid` held high with 0x00 then 0xFF queued.
  - two frames, with exactly 1 idle cycle between them;
  - period 45 cycles; exactly two handshakes.
- `s_data` toggled every cycle while busy.
  - the transmitted frame matches the word latched at the handshake;
  - no extra handshake occurs.
- `rst` pulsed for 1 cycle in the middle of data bit 3.
  - next cycle: `tx`=1, `busy`=0, `s_ready`=1, no `done`;
  - a fresh 0x3C frame sent afterwards is bit-exact.
